// File: rtl/rsa_module.sv
// rtl/rsa_module.sv - modular exponentiator (right-to-left square-and-multiply over one shift-add modular multiplier)
module rsa_module #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0] modulus,
    output logic [WIDTH-1:0] result,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {S_IDLE, S_REDUCE, S_MUL, S_SQR, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] base_q, base_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [WIDTH-1:0] mod_q, mod_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [CW-1:0]    bit_q, bit_d;
    logic [CW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] mm_a, mm_b, mm_p;
    logic [WIDTH+1:0] mod_x, p_dbl, p_red, p_add;
    logic             last_bit, last_k, exp_tail_zero, accept;

    // Shared multiplier operands depend only on which phase is running.
    always_comb begin
        mm_a = '0;
        mm_b = '0;
        case (state_q)
            S_REDUCE: begin mm_a = WIDTH'(1); mm_b = base_q; end
            S_MUL:    begin mm_a = r_q;       mm_b = x_q;    end
            S_SQR:    begin mm_a = x_q;       mm_b = x_q;    end
            default:  ;
        endcase
    end

    // One interleaved step: P = 2P mod N, then conditionally P = (P + A) mod N.
    always_comb begin
        mod_x = {2'b00, mod_q};
        p_dbl = {1'b0, p_q, 1'b0};
        p_red = (p_dbl >= mod_x) ? p_dbl - mod_x : p_dbl;
        p_add = p_red + (mm_b[bit_q] ? {2'b00, mm_a} : '0);
        mm_p  = (p_add >= mod_x) ? WIDTH'(p_add - mod_x) : WIDTH'(p_add);
    end

    assign last_bit      = (bit_q == '0);
    assign last_k        = (k_q == CW'(WIDTH - 1));
    assign exp_tail_zero = ((exp_q >> (k_q + CW'(1))) == '0);
    assign accept        = start && (state_q == S_IDLE || state_q == S_DONE);

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        exp_d    = exp_q;
        mod_d    = mod_q;
        x_d      = x_q;
        r_d      = r_q;
        p_d      = p_q;
        bit_d    = bit_q;
        k_d      = k_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            S_REDUCE: begin
                p_d   = mm_p;
                bit_d = bit_q - CW'(1);
                if (last_bit) begin
                    x_d     = mm_p;
                    r_d     = WIDTH'(1);
                    k_d     = '0;
                    p_d     = '0;
                    bit_d   = CW'(WIDTH - 1);
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                if (exp_q[k_q]) begin
                    p_d   = mm_p;
                    bit_d = bit_q - CW'(1);
                    if (last_bit) begin
                        r_d     = mm_p;
                        p_d     = '0;
                        bit_d   = CW'(WIDTH - 1);
                        state_d = S_SQR;
                    end
                end else begin
                    state_d = S_SQR;
                end
            end
            S_SQR: begin
                if (last_k || exp_tail_zero) begin
                    state_d = S_DONE;
                end else begin
                    p_d   = mm_p;
                    bit_d = bit_q - CW'(1);
                    if (last_bit) begin
                        x_d     = mm_p;
                        p_d     = '0;
                        bit_d   = CW'(WIDTH - 1);
                        k_d     = k_q + CW'(1);
                        state_d = S_MUL;
                    end
                end
            end
            S_DONE: begin
                result_d = r_q;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: ;
        endcase
        // A new operation may be taken in the same cycle DONE publishes the previous result.
        if (accept) begin
            base_d  = base;
            exp_d   = exponent;
            mod_d   = modulus;
            r_d     = '0;
            p_d     = '0;
            bit_d   = CW'(WIDTH - 1);
            k_d     = '0;
            state_d = (modulus <= WIDTH'(1)) ? S_DONE : S_REDUCE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            base_q   <= '0;
            exp_q    <= '0;
            mod_q    <= '0;
            x_q      <= '0;
            r_q      <= '0;
            p_q      <= '0;
            bit_q    <= '0;
            k_q      <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            exp_q    <= exp_d;
            mod_q    <= mod_d;
            x_q      <= x_d;
            r_q      <= r_d;
            p_q      <= p_d;
            bit_q    <= bit_d;
            k_q      <= k_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign result = result_q;
    assign done   = done_q;
endmodule

// File: tb/tb_rsa_module.sv
// tb/tb_rsa_module.sv - randomized and directed bench for rsa_module against an arithmetic model
module tb_rsa_module;
    localparam int WIDTH   = 12;
    localparam int MAX_LAT = 316;
    localparam int TIMEOUT = 400;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] base, exponent, modulus;
    logic [WIDTH-1:0] result;
    logic             done;

    int n_checks = 0;
    int n_errors = 0;

    rsa_module #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .start(start),
        .base(base), .exponent(exponent), .modulus(modulus),
        .result(result), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int unsigned ref_modexp(input int unsigned b, input int unsigned e, input int unsigned m);
        int unsigned r, x;
        if (m <= 1) return 0;
        r = 1;
        x = b % m;
        while (e != 0) begin
            if (e[0]) r = (r * x) % m;
            x = (x * x) % m;
            e = e >> 1;
        end
        return r;
    endfunction

    task automatic pulse_start(input int unsigned b, input int unsigned e, input int unsigned m);
        @(negedge clk);
        base = WIDTH'(b); exponent = WIDTH'(e); modulus = WIDTH'(m);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        base = WIDTH'($urandom); exponent = WIDTH'($urandom); modulus = WIDTH'($urandom);
    endtask

    task automatic run_op(input string tag, input int unsigned b, input int unsigned e, input int unsigned m);
        int lat;
        pulse_start(b, e, m);
        lat = 1;
        while (!done && lat < TIMEOUT) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_done_seen"}, 32'(done), 32'd1);
        check({tag, "_result"}, 32'(result), ref_modexp(b, e, m));
        check({tag, "_latency_ok"}, 32'(lat <= MAX_LAT), 32'd1);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    endtask

    initial begin
        int pulses;
        int unsigned rb, re, rm;
        rst = 1'b1; start = 1'b0; base = '0; exponent = '0; modulus = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_result", 32'(result), 32'd0);
        check("reset_done", 32'(done), 32'd0);

        run_op("encrypt", 65, 17, 3233);
        check("encrypt_abs", 32'(result), 32'd2790);
        run_op("decrypt", 2790, 2753, 3233);
        check("decrypt_abs", 32'(result), 32'd65);
        run_op("exp_zero", 5, 0, 3233);
        check("exp_zero_abs", 32'(result), 32'd1);
        run_op("mod_one", 77, 9, 1);
        run_op("mod_zero", 77, 9, 0);
        run_op("base_zero", 0, 17, 3233);
        run_op("unreduced", 4000, 1, 3233);
        check("unreduced_abs", 32'(result), 32'd767);
        run_op("base_eq_mod", 3233, 5, 3233);
        run_op("max_exp", 4095, 4095, 4093);

        // Start while busy must be ignored and produce exactly one done pulse.
        pulse_start(65, 17, 3233);
        repeat (20) @(negedge clk);
        pulse_start(123, 456, 789);
        pulses = 0;
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("busy_pulses", 32'(pulses), 32'd1);
        check("busy_result", 32'(result), 32'd2790);

        // Reset during the first squaring aborts with no done pulse.
        pulse_start(65, 17, 3233);
        repeat (28) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset_result", 32'(result), 32'd0);
        pulses = 0;
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("midreset_pulses", 32'(pulses), 32'd0);
        check("midreset_result_held", 32'(result), 32'd0);
        run_op("after_reset", 65, 17, 3233);

        for (int i = 0; i < 30; i++) begin
            rb = $urandom_range(4095, 0);
            re = (i % 5 == 0) ? $urandom_range(3, 0) : $urandom_range(4095, 0);
            rm = (i % 7 == 0) ? $urandom_range(3, 0) : $urandom_range(4095, 2);
            run_op($sformatf("rand%0d", i), rb, re, rm);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
